// File: rtl/mcu_trace_pkg.sv
// Shared types and constants for the CPU trace capture block.
// Latency: none (types and constants only).
// Backpressure: not applicable; CPU_TRACE_TIMESTAMP_EN adds a ts field to each entry.
package mcu_trace_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int TS_W_DEF   = 16;
    localparam logic [7:0] DROP_MAX = 8'hFF;

`ifdef CPU_TRACE_TIMESTAMP_EN
    localparam bit TS_STORED = 1'b1;
`else
    localparam bit TS_STORED = 1'b0;
`endif

    // One trace record at the default widths
    typedef struct packed {
`ifdef CPU_TRACE_TIMESTAMP_EN
        logic [TS_W_DEF-1:0]   ts;
`endif
        logic [DATA_W_DEF-1:0] w;
        logic [DATA_W_DEF-1:0] ram;
    } trace_entry_t;

    // Storage width of one entry for arbitrary data/timestamp widths
    function automatic int entry_bits(input int dw, input int tw);
        return 2 * dw + (TS_STORED ? tw : 0);
    endfunction

endpackage

// File: rtl/cpu_trace_capture_fifo_mem.sv
// First-word-fall-through storage for trace entries: array, pointers, occupancy.
// Latency: a pushed entry is visible at the head one clock after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle; head reads 0 when empty.
module trace_fifo_mem #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wr_dat,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_acc;
    logic          pop_acc;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_acc = push & (~full | pop);
    assign pop_acc  = pop & ~empty;

    // Head is shown without a read request; an empty FIFO never exposes old data
    assign rd_dat = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrap modulo DEPTH) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_acc) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push_acc) - CW'(pop_acc);
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cpu_trace_capture.sv
// Captures CPU w/ram outputs into a trace FIFO whenever either changes; CPU_TRACE_TIMESTAMP_EN adds timestamps.
// Latency: entry sampled at edge N is at the head with rd_valid high after edge N.
// Backpressure: rd_valid/rd_ready drain; pushes into a full FIFO without a pop are dropped and counted.
module cpu_trace_capture
    import mcu_trace_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 16,
    parameter int TS_W   = TS_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cap_en,
    input  logic [DATA_W-1:0]        w_in,
    input  logic [DATA_W-1:0]        ram_in,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_w,
    output logic [DATA_W-1:0]        rd_ram,
`ifdef CPU_TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]          rd_ts,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = entry_bits(DATA_W, TS_W);

    typedef struct packed {
`ifdef CPU_TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] ram;
    } entry_t;

    logic [DATA_W-1:0] prev_w_q, prev_w_d;
    logic [DATA_W-1:0] prev_ram_q, prev_ram_d;
    logic              primed_q, primed_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
`ifdef CPU_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts_q, ts_d;
`endif

    logic              push_req;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    entry_t            wr_entry;
    entry_t            rd_entry;

    // Change detector; an unprimed capture always records its first sample
    assign push_req = cap_en & (~primed_q | (w_in != prev_w_q) | (ram_in != prev_ram_q));
    assign pop      = rd_valid & rd_ready;
    assign drop     = push_req & fifo_full & ~pop;
    assign rd_valid = ~fifo_empty;

    // Pack the sampled values (and the pre-edge timestamp) into one entry
    always_comb begin
        wr_entry     = '0;
        wr_entry.w   = w_in;
        wr_entry.ram = ram_in;
`ifdef CPU_TRACE_TIMESTAMP_EN
        wr_entry.ts  = ts_q;
`endif
    end

    trace_fifo_mem #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push_req),
        .pop    (pop),
        .wr_dat (wr_entry),
        .rd_dat (rd_entry),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign rd_w     = rd_entry.w;
    assign rd_ram   = rd_entry.ram;
`ifdef CPU_TRACE_TIMESTAMP_EN
    assign rd_ts    = rd_entry.ts;
`endif
    assign count    = fifo_count;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    // Next-state for sampling history, drop bookkeeping and the timestamp counter
    always_comb begin
        prev_w_d   = prev_w_q;
        prev_ram_d = prev_ram_q;
        primed_d   = primed_q;
        if (cap_en) begin
            prev_w_d   = w_in;
            prev_ram_d = ram_in;
            primed_d   = 1'b1;
        end
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != DROP_MAX)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
`ifdef CPU_TRACE_TIMESTAMP_EN
        ts_d = ts_q + TS_W'(1);
`endif
    end

    // Control registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_w_q   <= '0;
            prev_ram_q <= '0;
            primed_q   <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
`ifdef CPU_TRACE_TIMESTAMP_EN
            ts_q       <= '0;
`endif
        end else begin
            prev_w_q   <= prev_w_d;
            prev_ram_q <= prev_ram_d;
            primed_q   <= primed_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef CPU_TRACE_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Bench for cpu_trace_capture: vector table plus scoreboard-driven multi-cycle sequences.
// Latency: checks are sampled 1 time unit after each rising edge.
// Backpressure: exercises full/overflow, simultaneous push+pop, empty reads and async reset.
module tb_cpu_trace_capture;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              cap_en;
    logic [DATA_W-1:0] w_in;
    logic [DATA_W-1:0] ram_in;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_w;
    logic [DATA_W-1:0] rd_ram;
`ifdef CPU_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   rd_ts;
`endif
    logic [CW-1:0]     count;
    logic              overflow;
    logic [7:0]        drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] w;
        logic [7:0] ram;
    } ent_t;

    ent_t sb[$];

    typedef struct {
        logic       en;
        logic [7:0] w;
        logic [7:0] ram;
        logic       rdy;
        int         exp_cnt;
        logic       exp_vld;
        logic [7:0] exp_w;
        logic [7:0] exp_ram;
    } vec_t;

    vec_t tbl[13];

    cpu_trace_capture #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cap_en   (cap_en),
        .w_in     (w_in),
        .ram_in   (ram_in),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_w     (rd_w),
        .rd_ram   (rd_ram),
`ifdef CPU_TRACE_TIMESTAMP_EN
        .rd_ts    (rd_ts),
`endif
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [7:0] w, input logic [7:0] ram, input logic rdy);
        cap_en   = en;
        w_in     = w;
        ram_in   = ram;
        rd_ready = rdy;
    endtask

    // Compare the DUT head against the oldest scoreboard entry
    task automatic expect_head(input string name);
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'(rd_valid), 32'd0);
        end else begin
            chk({name, "_vld"}, 32'(rd_valid), 32'd1);
            chk({name, "_w"},   32'(rd_w),     32'(sb[0].w));
            chk({name, "_ram"}, 32'(rd_ram),   32'(sb[0].ram));
        end
    endtask

    initial begin
        int exp_drop;

        //          en  w      ram    rdy cnt vld exp_w  exp_ram
        tbl[0]  = '{1, 8'h05, 8'h00, 0,  1,  1, 8'h05, 8'h00};
        tbl[1]  = '{1, 8'h05, 8'h00, 0,  1,  1, 8'h05, 8'h00};
        tbl[2]  = '{1, 8'h05, 8'h00, 0,  1,  1, 8'h05, 8'h00};
        tbl[3]  = '{1, 8'h05, 8'h0A, 0,  2,  1, 8'h05, 8'h00};
        tbl[4]  = '{1, 8'h05, 8'h0A, 0,  2,  1, 8'h05, 8'h00};
        tbl[5]  = '{0, 8'h77, 8'h77, 0,  2,  1, 8'h05, 8'h00};
        tbl[6]  = '{1, 8'h05, 8'h0A, 1,  1,  1, 8'h05, 8'h0A};
        tbl[7]  = '{1, 8'h05, 8'h0A, 1,  0,  0, 8'h00, 8'h00};
        tbl[8]  = '{1, 8'h05, 8'h0A, 1,  0,  0, 8'h00, 8'h00};
        tbl[9]  = '{1, 8'h06, 8'h0A, 0,  1,  1, 8'h06, 8'h0A};
        tbl[10] = '{1, 8'h06, 8'h0A, 1,  0,  0, 8'h00, 8'h00};
        tbl[11] = '{1, 8'h07, 8'h0B, 1,  1,  1, 8'h07, 8'h0B};
        tbl[12] = '{1, 8'h07, 8'h0B, 1,  0,  0, 8'h00, 8'h00};

        reset = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_valid",    32'(rd_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop",     32'(drop_cnt), 32'd0);
        chk("rst_rd_w",     32'(rd_w),     32'd0);
        chk("rst_rd_ram",   32'(rd_ram),   32'd0);
        tick();
        reset = 1'b0;

        // Change detection, hold while disabled, FWFT reads, empty reads
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].en, tbl[i].w, tbl[i].ram, tbl[i].rdy);
            tick();
            chk($sformatf("tbl%0d_count", i), 32'(count),    32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].exp_vld));
            chk($sformatf("tbl%0d_w", i),     32'(rd_w),     32'(tbl[i].exp_w));
            chk($sformatf("tbl%0d_ram", i),   32'(rd_ram),   32'(tbl[i].exp_ram));
            chk($sformatf("tbl%0d_ovf", i),   32'(overflow), 32'd0);
        end

        // Overfill: 20 distinct samples into a 16-deep FIFO, nothing read
        exp_drop = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(8'h10 + i), 8'(8'h80 + i), 1'b0);
            if (sb.size() < DEPTH) sb.push_back('{8'(8'h10 + i), 8'(8'h80 + i)});
            else exp_drop++;
            tick();
        end
        chk("fill_count",    32'(count),    32'(DEPTH));
        chk("fill_overflow", 32'(overflow), 32'd1);
        chk("fill_drop",     32'(drop_cnt), 32'(exp_drop));
        expect_head("fill_head");

        // Full FIFO with a pop and a new sample in the same cycle
        drive(1'b1, 8'hA0, 8'hA0, 1'b1);
        expect_head("fullpop_head");
        void'(sb.pop_front());
        sb.push_back('{8'hA0, 8'hA0});
        tick();
        chk("fullpop_count", 32'(count),    32'(DEPTH));
        chk("fullpop_drop",  32'(drop_cnt), 32'(exp_drop));
        expect_head("fullpop_next");

        // Drop counter saturation while the FIFO stays full
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 8'(i), 8'hA0, 1'b0);
            if (exp_drop < 255) exp_drop++;
            tick();
        end
        chk("sat_drop",  32'(drop_cnt), 32'd255);
        chk("sat_count", 32'(count),    32'(DEPTH));

        // Drain: order must match what was accepted
        drive(1'b0, 8'hEE, 8'hEE, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            expect_head($sformatf("drain%0d", k));
            tick();
            void'(sb.pop_front());
        end
        chk("drain_count", 32'(count),    32'd0);
        chk("drain_valid", 32'(rd_valid), 32'd0);
        chk("drain_w",     32'(rd_w),     32'd0);

        // Asynchronous reset with 7 entries queued
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'(8'h30 + i), 8'h55, 1'b0);
            sb.push_back('{8'(8'h30 + i), 8'h55});
            tick();
        end
        chk("pre_rst_count", 32'(count), 32'd7);
        reset = 1'b1;
        #1;
        chk("arst_count",    32'(count),    32'd0);
        chk("arst_valid",    32'(rd_valid), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        chk("arst_drop",     32'(drop_cnt), 32'd0);
        sb.delete();
        tick();
        reset = 1'b0;
        // Inputs equal to the reset history still push on the first enabled cycle
        drive(1'b1, 8'h00, 8'h00, 1'b0);
        sb.push_back('{8'h00, 8'h00});
        tick();
        chk("reprime_count", 32'(count), 32'd1);
        expect_head("reprime_head");
        tick();
        chk("reprime_hold", 32'(count), 32'd1);
        drive(1'b1, 8'h00, 8'h00, 1'b1);
        tick();
        void'(sb.pop_front());
        chk("reprime_drain", 32'(count), 32'd0);

`ifdef CPU_TRACE_TIMESTAMP_EN
        // Timestamps: pushes at counter values 3 and 10, then one after the wrap
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) tick();
        drive(1'b1, 8'h11, 8'h22, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (6) tick();
        drive(1'b1, 8'h33, 8'h44, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (65530) tick();
        drive(1'b1, 8'h55, 8'h66, 1'b0);
        tick();
        chk("ts_count", 32'(count), 32'd3);
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        chk("ts_first", 32'(rd_ts), 32'd3);
        chk("ts_first_w", 32'(rd_w), 32'h11);
        tick();
        chk("ts_second", 32'(rd_ts), 32'd10);
        tick();
        chk("ts_wrap", 32'(rd_ts), 32'd5);
        tick();
        chk("ts_empty", 32'(rd_ts), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
